// File: rtl/img_pkg.sv
// Shared definitions for the frame-buffered pixel filters and their sequencer:
// the frame state encoding, default image geometry and sizing helpers.
package img_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_GAP   = 3'd2,
        ST_PROC  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam int DEF_WIDTH = 1080;
    localparam int DEF_DEPTH = 1080;
    localparam int DEF_PIX_W = 8;

    // Pixels per frame.
    function automatic int calc_n(input int width, input int depth);
        return width * depth;
    endfunction

    // Counter width able to hold 0..N inclusive.
    function automatic int calc_cw(input int width, input int depth);
        return $clog2(width * depth + 1);
    endfunction

endpackage

// File: rtl/valid_delay.sv
// LAT-stage shift register carrying a valid flag and its last marker, used to
// line the capture stage up with the filter's result latency. LAT=0 is a
// straight pass-through.
module valid_delay #(
    parameter int LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  logic in_last,
    output logic out_valid,
    output logic out_last
);

    generate
        if (LAT == 0) begin : g_pass
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign out_valid      = in_valid;
            assign out_last       = in_last;
        end else if (LAT == 1) begin : g_one
            logic v_q;
            logic l_q;
            // Single stage: last only travels alongside a valid.
            always_ff @(posedge clk) begin
                if (rst) begin
                    v_q <= 1'b0;
                    l_q <= 1'b0;
                end else begin
                    v_q <= in_valid;
                    l_q <= in_valid & in_last;
                end
            end
            assign out_valid = v_q;
            assign out_last  = l_q;
        end else begin : g_shift
            logic [LAT-1:0] v_sr;
            logic [LAT-1:0] l_sr;
            // Multi-stage shift; reset flushes anything in flight.
            always_ff @(posedge clk) begin
                if (rst) begin
                    v_sr <= '0;
                    l_sr <= '0;
                end else begin
                    v_sr <= {v_sr[LAT-2:0], in_valid};
                    l_sr <= {l_sr[LAT-2:0], in_valid & in_last};
                end
            end
            assign out_valid = v_sr[LAT-1];
            assign out_last  = l_sr[LAT-1];
        end
    endgenerate

endmodule

// File: rtl/frame_sequencer.sv
// Drives a frame-buffered filter through load, settle gap and process phases
// and captures its per-cycle result as a framed output stream.
//
// Upstream handshake: a pixel transfers on every rising edge where
// in_valid && in_ready are both high; in_ready is high only in LOAD and does
// not depend on in_valid. in_valid may drop at any time (stall). There is no
// downstream backpressure: out_valid pulses must be taken every cycle.
module frame_sequencer
    import img_pkg::*;
#(
    parameter int  WIDTH = DEF_WIDTH,
    parameter int  DEPTH = DEF_DEPTH,
    parameter int  PIX_W = DEF_PIX_W,
    parameter int  GAP   = 2,
    parameter int  LAT   = 1,
    localparam int CW    = calc_cw(WIDTH, DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [PIX_W-1:0] in_data,
    output logic             in_ready,
    output logic [PIX_W-1:0] filt_pixel,
    output logic             filt_en,
    output logic             filt_en_proc,
    input  logic [PIX_W-1:0] filt_result,
    output logic             out_valid,
    output logic [PIX_W-1:0] out_data,
    output logic             out_last,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    pix_count,
    output state_t           state_dbg
);

    localparam int N  = calc_n(WIDTH, DEPTH);
    localparam int AW = $clog2(((GAP > LAT) ? GAP : LAT) + 1);

    localparam logic [CW-1:0] N_C    = CW'(N);
    localparam logic [CW-1:0] N_M1   = CW'(N - 1);
    localparam logic [AW-1:0] GAP_C  = AW'(GAP);
    localparam logic [AW-1:0] LAT_M1 = (LAT > 0) ? AW'(LAT - 1) : '0;

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   pix_nx;
    logic [CW-1:0]   pix_inc;
    logic [AW-1:0]   aux_cnt;
    logic [AW-1:0]   aux_nx;
    logic            accept;
    logic            proc_last;
    logic            cap_valid;
    logic            cap_last;

    assign state_dbg = state;

    // Phase counter saturates at N so it can never wrap into a new frame.
    assign pix_inc = (pix_count == N_C) ? N_C : pix_count + CW'(1);

    // Next-state and counter update. pix_count indexes the LOAD/PROC phases;
    // aux_cnt times the GAP and DRAIN phases.
    always_comb begin
        state_nx = state;
        pix_nx   = pix_count;
        aux_nx   = aux_cnt;
        accept   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx = ST_LOAD;
                    pix_nx   = '0;
                end
            end
            ST_LOAD: begin
                accept = in_valid && in_ready;
                if (accept) begin
                    pix_nx = pix_inc;
                    if (pix_count == N_M1) begin
                        state_nx = ST_GAP;
                        aux_nx   = '0;
                    end
                end
            end
            ST_GAP: begin
                // The first GAP cycle still carries the final load strobe,
                // so GAP idle cycles follow it before processing starts.
                if (aux_cnt == GAP_C) begin
                    state_nx = ST_PROC;
                    pix_nx   = '0;
                end else begin
                    aux_nx = aux_cnt + AW'(1);
                end
            end
            ST_PROC: begin
                pix_nx = pix_inc;
                if (pix_count == N_M1) begin
                    state_nx = (LAT == 0) ? ST_DONE : ST_DRAIN;
                    aux_nx   = '0;
                end
            end
            ST_DRAIN: begin
                if (aux_cnt == LAT_M1) begin
                    state_nx = ST_DONE;
                end else begin
                    aux_nx = aux_cnt + AW'(1);
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // State register plus registered control outputs derived from next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            pix_count    <= '0;
            aux_cnt      <= '0;
            in_ready     <= 1'b0;
            filt_en      <= 1'b0;
            filt_en_proc <= 1'b0;
            filt_pixel   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_nx;
            pix_count    <= pix_nx;
            aux_cnt      <= aux_nx;
            in_ready     <= (state_nx == ST_LOAD);
            filt_en      <= accept;
            filt_en_proc <= (state_nx == ST_PROC);
            busy         <= (state_nx != ST_IDLE);
            // DONE coincides with the capture of the final pixel, so the
            // pulse lands one cycle after out_last.
            done         <= (state == ST_DONE);
            if (accept) begin
                filt_pixel <= in_data;
            end
        end
    end

    // filt_en_proc is high exactly while in PROC, so pix_count is the index
    // of the pixel being processed in that cycle.
    assign proc_last = filt_en_proc && (pix_count == N_M1);

    valid_delay #(
        .LAT(LAT)
    ) u_align (
        .clk      (clk),
        .rst      (rst),
        .in_valid (filt_en_proc),
        .in_last  (proc_last),
        .out_valid(cap_valid),
        .out_last (cap_last)
    );

    // Capture register: sample the filter result when the aligned valid says
    // it belongs to a processed pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= cap_valid;
            out_last  <= cap_valid & cap_last;
            if (cap_valid) begin
                out_data <= filt_result;
            end
        end
    end

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: two builds (LAT=1 and LAT=0) share stimulus,
// each wired to a behavioural brightness filter (+20, clamped at 255).
module tb_frame_sequencer;
  import img_pkg::*;

  localparam int PW = 8;
  localparam int NPIX = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [PW-1:0] in_data = '0;

  logic          in_ready, filt_en, filt_en_proc, out_valid, out_last, busy, done;
  logic [PW-1:0] filt_pixel, filt_result, out_data;
  logic [3:0]    pix_count;
  state_t        state_dbg;

  logic          l0_in_ready, l0_filt_en, l0_filt_en_proc, l0_out_valid, l0_out_last, l0_busy, l0_done;
  logic [PW-1:0] l0_filt_pixel, l0_filt_result, l0_out_data;
  logic [3:0]    l0_pix_count;
  state_t        l0_state_dbg;

  frame_sequencer #(.WIDTH(4), .DEPTH(2), .PIX_W(PW), .GAP(2), .LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .filt_pixel(filt_pixel), .filt_en(filt_en),
    .filt_en_proc(filt_en_proc), .filt_result(filt_result), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .busy(busy), .done(done),
    .pix_count(pix_count), .state_dbg(state_dbg)
  );

  frame_sequencer #(.WIDTH(4), .DEPTH(2), .PIX_W(PW), .GAP(2), .LAT(0)) dut_l0 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(l0_in_ready), .filt_pixel(l0_filt_pixel), .filt_en(l0_filt_en),
    .filt_en_proc(l0_filt_en_proc), .filt_result(l0_filt_result), .out_valid(l0_out_valid),
    .out_data(l0_out_data), .out_last(l0_out_last), .busy(l0_busy), .done(l0_done),
    .pix_count(l0_pix_count), .state_dbg(l0_state_dbg)
  );

  function automatic logic [PW-1:0] bright(input logic [PW-1:0] p);
    logic [PW:0] s;
    s = {1'b0, p} + 9'd20;
    return s[PW] ? 8'hFF : s[PW-1:0];
  endfunction

  // ---------------- behavioural filters ----------------
  logic [PW-1:0] fm1 [NPIX];
  logic [2:0]    f1_lp, f1_pp;
  always @(posedge clk) begin
    if (rst) begin
      f1_lp <= '0; f1_pp <= '0; filt_result <= '0;
    end else begin
      if (filt_en) begin fm1[f1_lp] <= filt_pixel; f1_lp <= f1_lp + 3'd1; end
      if (filt_en_proc) begin filt_result <= bright(fm1[f1_pp]); f1_pp <= f1_pp + 3'd1; end
    end
  end

  logic [PW-1:0] fm0 [NPIX];
  logic [2:0]    f0_lp, f0_pp;
  assign l0_filt_result = bright(fm0[f0_pp]);
  always @(posedge clk) begin
    if (rst) begin
      f0_lp <= '0; f0_pp <= '0;
    end else begin
      if (l0_filt_en) begin fm0[f0_lp] <= l0_filt_pixel; f0_lp <= f0_lp + 3'd1; end
      if (l0_filt_en_proc) f0_pp <= f0_pp + 3'd1;
    end
  end

  // ---------------- scoreboard ----------------
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] exp_q0[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  int t0 = 0;
  int n_en, n_proc, n_out, n_done, first_en, last_en, first_proc, first_out, done_cyc;
  int n_out0, n_done0, first_proc0, first_out0, done_cyc0;
  logic prev_last = 1'b0;

  task automatic clear_stats();
    n_en = 0; n_proc = 0; n_out = 0; n_done = 0;
    first_en = -1; last_en = -1; first_proc = -1; first_out = -1; done_cyc = -1;
    n_out0 = 0; n_done0 = 0; first_proc0 = -1; first_out0 = -1; done_cyc0 = -1;
  endtask

  // Monitor for the LAT=1 build: strobes, output stream and done.
  always @(negedge clk) begin
    logic [31:0] exp_d;
    if (filt_en) begin
      n_en++;
      if (first_en < 0) first_en = cyc;
      last_en = cyc;
    end
    if (filt_en_proc) begin
      n_proc++;
      if (first_proc < 0) begin
        first_proc = cyc;
        check("busy_proc", busy, 1);
      end
    end
    if (filt_en || filt_en_proc) check("en_excl", filt_en & filt_en_proc, 0);
    if (out_valid) begin
      exp_d = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hDEAD_BEEF;
      check("out_data", out_data, exp_d);
      check("out_last", out_last, n_out == NPIX - 1);
      n_out++;
      if (first_out < 0) first_out = cyc;
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
      check("done_after_last", prev_last, 1);
    end
    prev_last = out_last;
  end

  // Monitor for the LAT=0 build.
  always @(negedge clk) begin
    logic [31:0] exp_d;
    if (l0_filt_en_proc && first_proc0 < 0) first_proc0 = cyc;
    if (l0_out_valid) begin
      exp_d = (exp_q0.size() > 0) ? 32'(exp_q0.pop_front()) : 32'hDEAD_BEEF;
      check("l0_out_data", l0_out_data, exp_d);
      n_out0++;
      if (first_out0 < 0) first_out0 = cyc;
    end
    if (l0_done) begin
      n_done0++;
      done_cyc0 = cyc;
    end
  end

  // ---------------- driver tasks ----------------
  // Loads nload pixels (stalling stall_len cycles after the 4th), optionally
  // pokes start during PROC, then waits for done unless the frame is partial.
  task automatic run_frame(input int nload, input int stall_len, input bit sat, input bit poke);
    logic [PW-1:0] pix [NPIX];
    logic rdy;
    int i, stalled, guard;
    for (int k = 0; k < NPIX; k++) pix[k] = sat ? PW'($urandom_range(0, 255)) : PW'(k * 10);
    if (sat) pix[3] = 8'd250;
    clear_stats();
    @(posedge clk); #1;
    start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    i = 0; stalled = 0; guard = 0;
    while (i < nload && guard < 200) begin
      guard++;
      if (i == 4 && stalled < stall_len) begin
        in_valid = 1'b0;
        stalled++;
      end else begin
        in_valid = 1'b1;
        in_data = pix[i];
      end
      @(negedge clk); rdy = in_ready;
      @(posedge clk); #1;
      if (in_valid && rdy) begin
        exp_q.push_back(bright(pix[i]));
        exp_q0.push_back(bright(pix[i]));
        i++;
      end
    end
    in_valid = 1'b0;
    check("load_count", i, nload);
    check("pix_count_load", pix_count, nload);
    if (nload < NPIX) return;
    if (poke) begin
      guard = 0;
      while (n_proc == 0 && guard < 50) begin @(negedge clk); guard++; end
      @(posedge clk); #1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
    end
    guard = 0;
    while (n_done == 0 && guard < 100) begin @(negedge clk); guard++; end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_frame(input int stall_len);
    check("n_en", n_en, NPIX);
    check("n_proc", n_proc, NPIX);
    check("n_out", n_out, NPIX);
    check("n_done", n_done, 1);
    check("first_en", first_en - t0, 2);
    check("en_holes", last_en - first_en + 1 - n_en, stall_len);
    check("gap_idle", first_proc - last_en - 1, 2);
    check("out_lat", first_out - first_proc, 2);
    check("frame_len", done_cyc - t0, 22 + stall_len);
    check("q_empty", exp_q.size(), 0);
    check("busy_idle", busy, 0);
    check("state_idle", 32'(state_dbg), 32'(ST_IDLE));
    check("pix_count_end", pix_count, NPIX);
    check("l0_n_out", n_out0, NPIX);
    check("l0_n_done", n_done0, 1);
    check("l0_out_lat", first_out0 - first_proc0, 1);
    check("l0_frame_len", done_cyc0 - t0, 21 + stall_len);
    check("l0_q_empty", exp_q0.size(), 0);
  endtask

  // ---------------- sequence ----------------
  initial begin
    clear_stats();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_zero", {in_ready, filt_en, filt_en_proc, out_valid, out_last, busy, done,
                       filt_pixel, out_data, pix_count}, 0);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));

    // nominal frame
    run_frame(NPIX, 0, 1'b0, 1'b0);
    check_frame(0);

    // upstream stall after the 4th pixel
    run_frame(NPIX, 3, 1'b0, 1'b0);
    check_frame(3);

    // random pixels with a clamping value
    run_frame(NPIX, 0, 1'b1, 1'b0);
    check_frame(0);

    // start pulsed during PROC is ignored
    run_frame(NPIX, 0, 1'b0, 1'b1);
    check_frame(0);

    // a second start afterwards runs a clean frame
    run_frame(NPIX, 0, 1'b1, 1'b0);
    check_frame(0);

    // reset in the middle of LOAD
    run_frame(5, 0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_zero", {in_ready, filt_en, filt_en_proc, out_valid, out_last, busy, done,
                           filt_pixel, out_data, pix_count}, 0);
    check("rst_mid_l0_zero", {l0_in_ready, l0_filt_en, l0_busy, l0_pix_count}, 0);
    exp_q.delete();
    exp_q0.delete();
    repeat (30) @(negedge clk);
    check("rst_no_done", n_done + n_done0, 0);
    check("rst_no_out", n_out + n_out0, 0);

    // frame after the reset completes normally
    run_frame(NPIX, 0, 1'b0, 1'b0);
    check_frame(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
